servo_pwm_multi: RTL and testbench

SERVO_PWM_MULTI -- requirements
Module: servo_pwm_multi

---
 rtl/servo_pkg.sv | 48 ++++
 rtl/servo_pwm_ch.sv | 59 +++++
 rtl/servo_pwm_multi.sv | 216 +++++++++++++++++++++
 tb/tb_servo_pwm_multi.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// servo_pkg: shared constants for the multi-channel servo PWM block.
// Holds register byte offsets and their word indices, CTRL bit positions,
// AXI response codes, the default frame length, the AXI handshake state
// types and a byte-strobe merge helper.
package servo_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned DEF_PERIOD_RST = 2000000;  // 20 ms at 100 MHz
  localparam int unsigned PERIOD_MIN     = 2;

  // Register byte offsets
  localparam int unsigned OFF_CTRL    = 32'h00;
  localparam int unsigned OFF_PERIOD  = 32'h04;
  localparam int unsigned OFF_STEP    = 32'h08;
  localparam int unsigned OFF_STATUS  = 32'h0C;
  localparam int unsigned OFF_TARGET0 = 32'h10;

  // Word indices used by the decoder
  localparam int unsigned IDX_CTRL    = OFF_CTRL / 4;
  localparam int unsigned IDX_PERIOD  = OFF_PERIOD / 4;
  localparam int unsigned IDX_STEP    = OFF_STEP / 4;
  localparam int unsigned IDX_STATUS  = OFF_STATUS / 4;
  localparam int unsigned IDX_TARGET0 = OFF_TARGET0 / 4;

  // CTRL bit positions
  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_SLEW_EN = 1;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WR_IDLE, WR_ACK, WR_RESP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_ACK, RD_DATA} rd_state_t;

  // Merge new_val into old_val byte-by-byte under strb
  function automatic logic [DATA_W-1:0] apply_strb(input logic [DATA_W-1:0] old_val,
                                                   input logic [DATA_W-1:0] new_val,
                                                   input logic [DATA_W/8-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int b = 0; b < int'(DATA_W / 8); b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/servo_pwm_ch.sv
// servo_pwm_ch: one servo channel. Slews the current pulse width toward the
// target once per frame and compares it against the shared frame counter.
// Ports:
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   i_frame_start       high on the cycle the frame counter sits at 0 while enabled
//   i_en                channel output enable (CTRL.EN)
//   i_slew_en, i_step   slew mode and per-frame step size
//   i_target            requested pulse width in clocks
//   i_cnt               shared frame counter
//   o_pwm               registered pulse output
//   o_at_target_c       current width equals target (combinational)
module servo_pwm_ch
  import servo_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_frame_start,
  input  logic              i_en,
  input  logic              i_slew_en,
  input  logic [DATA_W-1:0] i_step,
  input  logic [DATA_W-1:0] i_target,
  input  logic [DATA_W-1:0] i_cnt,
  output logic              o_pwm,
  output logic              o_at_target_c
);

  logic [DATA_W-1:0] r_cur;
  logic              r_pwm;
  logic [DATA_W-1:0] w_diff;
  logic [DATA_W-1:0] w_delta;
  logic [DATA_W-1:0] w_cur_nxt;

  // Next width; delta is clamped to the remaining distance so it never overshoots or wraps
  always_comb begin
    w_diff    = (i_target >= r_cur) ? (i_target - r_cur) : (r_cur - i_target);
    w_delta   = (w_diff < i_step) ? w_diff : i_step;
    w_cur_nxt = r_cur;
    if (i_frame_start) begin
      if (!i_slew_en || (i_step == '0)) w_cur_nxt = i_target;
      else if (i_target >= r_cur)       w_cur_nxt = r_cur + w_delta;
      else                              w_cur_nxt = r_cur - w_delta;
    end
  end

  // Compare uses the width being loaded so the new frame starts with the new width
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cur <= '0;
      r_pwm <= 1'b0;
    end else begin
      r_cur <= w_cur_nxt;
      r_pwm <= i_en && (i_cnt < w_cur_nxt);
    end
  end

  assign o_pwm         = r_pwm;
  assign o_at_target_c = (r_cur == i_target);

endmodule

// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: NUM_CH-channel servo PWM generator with an AXI4-Lite
// register interface (CTRL, PERIOD, STEP, STATUS, TARGET[i]).
// Ports:
//   ACLK, ARESETN         clock, synchronous active-low reset
//   S_AXI_AW*/W*/B*       AXI4-Lite write address/data/response channels
//   S_AXI_AR*/R*          AXI4-Lite read address/data channels
//   pwm_out[NUM_CH]       registered servo pulses
//   frame_tick            one-cycle pulse at each frame start
module servo_pwm_multi
  import servo_pkg::*;
#(
  parameter int unsigned NUM_CH             = 4,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 7,
  parameter int unsigned DEF_PERIOD         = DEF_PERIOD_RST
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [NUM_CH-1:0]                 pwm_out,
  output logic                              frame_tick
);

  localparam int unsigned LAST_IDX = IDX_TARGET0 + NUM_CH;  // first invalid word index

  wr_state_t         r_wr_state, w_wr_state_nxt;
  rd_state_t         r_rd_state, w_rd_state_nxt;
  logic [1:0]        r_bresp;
  logic [1:0]        r_rresp;
  logic [DATA_W-1:0] r_rdata;

  logic [1:0]        r_ctrl;
  logic [DATA_W-1:0] r_period;
  logic [DATA_W-1:0] r_step;
  logic [DATA_W-1:0] r_target [NUM_CH];
  logic [DATA_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_period_act;
  logic              r_frame_tick;

  logic [DATA_W-1:0] w_aw_word;
  logic [DATA_W-1:0] w_ar_word;
  logic              w_aw_ok;
  logic              w_ar_ok;
  logic              w_wr_fire;
  logic              w_rd_fire;
  logic [DATA_W-1:0] w_rd_data;
  logic [DATA_W-1:0] w_period_eff;
  logic              w_en;
  logic              w_frame_start;
  logic [NUM_CH-1:0] w_pwm;
  logic [NUM_CH-1:0] w_at_target;
  logic              w_unused;

  assign w_unused  = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  assign w_aw_word = DATA_W'(S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2]);
  assign w_ar_word = DATA_W'(S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]);
  assign w_aw_ok   = (w_aw_word < LAST_IDX);
  assign w_ar_ok   = (w_ar_word < LAST_IDX);
  assign w_wr_fire = (r_wr_state == WR_ACK);
  assign w_rd_fire = (r_rd_state == RD_ACK);

  // Write handshake state register
  always_ff @(posedge ACLK) begin
    if (!ARESETN) r_wr_state <= WR_IDLE;
    else          r_wr_state <= w_wr_state_nxt;
  end

  // Write handshake: wait for both AW and W, ready for one cycle, then hold B
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    case (r_wr_state)
      WR_IDLE: if (S_AXI_AWVALID && S_AXI_WVALID) w_wr_state_nxt = WR_ACK;
      WR_ACK:  w_wr_state_nxt = WR_RESP;
      WR_RESP: if (S_AXI_BREADY) w_wr_state_nxt = WR_IDLE;
      default: w_wr_state_nxt = WR_IDLE;
    endcase
  end

  // Read handshake state register
  always_ff @(posedge ACLK) begin
    if (!ARESETN) r_rd_state <= RD_IDLE;
    else          r_rd_state <= w_rd_state_nxt;
  end

  // Read handshake: ready for one cycle, then hold R until accepted
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    case (r_rd_state)
      RD_IDLE: if (S_AXI_ARVALID) w_rd_state_nxt = RD_ACK;
      RD_ACK:  w_rd_state_nxt = RD_DATA;
      RD_DATA: if (S_AXI_RREADY) w_rd_state_nxt = RD_IDLE;
      default: w_rd_state_nxt = RD_IDLE;
    endcase
  end

  assign S_AXI_AWREADY = (r_wr_state == WR_ACK);
  assign S_AXI_WREADY  = (r_wr_state == WR_ACK);
  assign S_AXI_BVALID  = (r_wr_state == WR_RESP);
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = (r_rd_state == RD_ACK);
  assign S_AXI_RVALID  = (r_rd_state == RD_DATA);
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_RDATA   = r_rdata;

  // Register file; STATUS writes fall through every match and are dropped
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_ctrl   <= '0;
      r_period <= DATA_W'(DEF_PERIOD);
      r_step   <= '0;
      r_bresp  <= RESP_OKAY;
      for (int i = 0; i < NUM_CH; i++) r_target[i] <= '0;
    end else if (w_wr_fire) begin
      r_bresp <= w_aw_ok ? RESP_OKAY : RESP_SLVERR;
      if (w_aw_word == IDX_CTRL)
        r_ctrl <= 2'(apply_strb(DATA_W'(r_ctrl), S_AXI_WDATA, S_AXI_WSTRB));
      if (w_aw_word == IDX_PERIOD)
        r_period <= apply_strb(r_period, S_AXI_WDATA, S_AXI_WSTRB);
      if (w_aw_word == IDX_STEP)
        r_step <= apply_strb(r_step, S_AXI_WDATA, S_AXI_WSTRB);
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_aw_word == IDX_TARGET0 + DATA_W'(i))
          r_target[i] <= apply_strb(r_target[i], S_AXI_WDATA, S_AXI_WSTRB);
      end
    end
  end

  // Read mux; out-of-range addresses read as zero
  always_comb begin
    w_rd_data = '0;
    case (w_ar_word)
      IDX_CTRL:   w_rd_data = DATA_W'(r_ctrl);
      IDX_PERIOD: w_rd_data = r_period;
      IDX_STEP:   w_rd_data = r_step;
      IDX_STATUS: w_rd_data = DATA_W'(w_at_target);
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (w_ar_word == IDX_TARGET0 + DATA_W'(i)) w_rd_data = r_target[i];
        end
      end
    endcase
  end

  // Read data captured at the handshake edge, so a same-cycle write is not visible
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else if (w_rd_fire) begin
      r_rdata <= w_rd_data;
      r_rresp <= w_ar_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign w_period_eff  = (r_period < DATA_W'(PERIOD_MIN)) ? DATA_W'(PERIOD_MIN) : r_period;
  assign w_en          = r_ctrl[CTRL_EN];
  assign w_frame_start = w_en && (r_cnt == '0);

  // Frame counter; PERIOD_ACT only reloads at a wrap or while disabled
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_cnt        <= '0;
      r_period_act <= DATA_W'(DEF_PERIOD);
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_frame_start;
      if (!w_en) begin
        r_cnt        <= '0;
        r_period_act <= w_period_eff;
      end else if (r_cnt >= r_period_act - 1) begin
        r_cnt        <= '0;
        r_period_act <= w_period_eff;
      end else begin
        r_cnt <= r_cnt + 1;
      end
    end
  end

  assign frame_tick = r_frame_tick;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    servo_pwm_ch u_ch (
      .i_clk         (ACLK),
      .i_rst_n       (ARESETN),
      .i_frame_start (w_frame_start),
      .i_en          (w_en),
      .i_slew_en     (r_ctrl[CTRL_SLEW_EN]),
      .i_step        (r_step),
      .i_target      (r_target[g]),
      .i_cnt         (r_cnt),
      .o_pwm         (w_pwm[g]),
      .o_at_target_c (w_at_target[g])
    );
  end

  assign pwm_out = w_pwm;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb_servo_pwm_multi: directed bench for servo_pwm_multi (NUM_CH=4).
// A register-access vector table followed by hand-written sequences for
// frame timing, slewing, period change, handshake stalls and reset.
module tb_servo_pwm_multi;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned AW     = 7;
  localparam int unsigned DW     = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [AW-1:0]     awaddr = '0;
  logic [2:0]        awprot = '0;
  logic              awvalid = 1'b0;
  logic              awready;
  logic [DW-1:0]     wdata = '0;
  logic [DW/8-1:0]   wstrb = '0;
  logic              wvalid = 1'b0;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready = 1'b0;
  logic [AW-1:0]     araddr = '0;
  logic [2:0]        arprot = '0;
  logic              arvalid = 1'b0;
  logic              arready;
  logic [DW-1:0]     rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready = 1'b0;
  logic [NUM_CH-1:0] pwm_out;
  logic              frame_tick;

  servo_pwm_multi #(.NUM_CH(NUM_CH)) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .pwm_out(pwm_out), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned tick_q[$];
  bit          tick_rec = 1'b0;
  always @(negedge clk) if (tick_rec && frame_tick) tick_q.push_back(cyc);

  int errors = 0;
  int checks = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT, required a response", name);
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) timeout("wr_awready");
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) timeout("wr_bvalid");
    resp = bresp;
    @(negedge clk);
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) timeout("rd_arready");
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) timeout("rd_rvalid");
    d = rdata; resp = rresp;
    @(negedge clk);
  endtask

  // Returns at the negedge where frame_tick is visible
  task automatic wait_tick();
    int n;
    @(negedge clk);
    n = 0;
    while (!frame_tick && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) timeout("wait_tick");
  endtask

  // Caller must be at a tick negedge; returns at the next tick negedge
  task automatic measure_frame(input int ch, output int hi, output int len);
    hi = 0; len = 0;
    do begin
      if (pwm_out[ch]) hi++;
      len++;
      @(negedge clk);
    end while (!frame_tick && len < 1000);
  endtask

  task automatic wait_ticks(input int cnt);
    int n;
    n = 0;
    while (tick_q.size() < cnt && n < 600) begin @(negedge clk); n++; end
    if (n >= 600) timeout("wait_ticks");
  endtask

  typedef struct {
    bit          is_wr;
    logic [6:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input bit w, input logic [6:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [31:0] ed, input logic [1:0] er);
    vec_t v;
    v.is_wr = w; v.addr = a; v.data = d; v.strb = s; v.exp_data = ed; v.exp_resp = er;
    return v;
  endfunction

  initial begin
    logic [31:0] rd;
    logic [1:0]  rsp;
    int          hi, len, bcnt, seen;
    int unsigned t0, c0;
    bit          early;

    repeat (3) @(negedge clk);
    check("reset_handshake_outs",
          32'({awready, wready, bvalid, arready, rvalid, bresp, rresp, frame_tick, pwm_out}), 32'h0);
    check("reset_rdata", rdata, 32'h0);
    rst_n = 1'b1;

    // Register access table: {write?, addr, data, strb, expected data, expected resp}
    vq.push_back(mk(0, 7'h00, 0, 0, 32'h0000_0000, 2'b00));
    vq.push_back(mk(0, 7'h04, 0, 0, 32'd2000000,   2'b00));
    vq.push_back(mk(0, 7'h08, 0, 0, 32'h0000_0000, 2'b00));
    vq.push_back(mk(0, 7'h0C, 0, 0, 32'h0000_000F, 2'b00));
    vq.push_back(mk(0, 7'h10, 0, 0, 32'h0000_0000, 2'b00));
    vq.push_back(mk(1, 7'h08, 32'h1234_5678, 4'hF, 0, 2'b00));
    vq.push_back(mk(0, 7'h08, 0, 0, 32'h1234_5678, 2'b00));
    vq.push_back(mk(1, 7'h08, 32'hAABB_CCDD, 4'h5, 0, 2'b00));
    vq.push_back(mk(0, 7'h08, 0, 0, 32'h12BB_56DD, 2'b00));
    vq.push_back(mk(1, 7'h0C, 32'hFFFF_FFFF, 4'hF, 0, 2'b00));
    vq.push_back(mk(0, 7'h0C, 0, 0, 32'h0000_000F, 2'b00));
    vq.push_back(mk(1, 7'h14, 32'hFFFF_FF7F, 4'h1, 0, 2'b00));
    vq.push_back(mk(0, 7'h14, 0, 0, 32'h0000_007F, 2'b00));
    vq.push_back(mk(0, 7'h0C, 0, 0, 32'h0000_000D, 2'b00));
    vq.push_back(mk(0, 7'h20, 0, 0, 32'h0000_0000, 2'b10));
    vq.push_back(mk(1, 7'h20, 32'h0000_0001, 4'hF, 0, 2'b10));
    vq.push_back(mk(0, 7'h7C, 0, 0, 32'h0000_0000, 2'b10));
    vq.push_back(mk(1, 7'h00, 32'h0000_0003, 4'h0, 0, 2'b00));
    vq.push_back(mk(0, 7'h00, 0, 0, 32'h0000_0000, 2'b00));
    vq.push_back(mk(1, 7'h00, 32'hFFFF_FFFC, 4'hF, 0, 2'b00));
    vq.push_back(mk(0, 7'h00, 0, 0, 32'h0000_0000, 2'b00));
    vq.push_back(mk(1, 7'h14, 32'h0000_0000, 4'hF, 0, 2'b00));
    vq.push_back(mk(1, 7'h08, 32'h0000_0000, 4'hF, 0, 2'b00));
    vq.push_back(mk(0, 7'h0C, 0, 0, 32'h0000_000F, 2'b00));

    foreach (vq[k]) begin
      if (vq[k].is_wr) begin
        axi_write(vq[k].addr, vq[k].data, vq[k].strb, rsp);
        check($sformatf("vec%0d_bresp@%02h", k, vq[k].addr), 32'(rsp), 32'(vq[k].exp_resp));
      end else begin
        axi_read(vq[k].addr, rd, rsp);
        check($sformatf("vec%0d_rdata@%02h", k, vq[k].addr), rd, vq[k].exp_data);
        check($sformatf("vec%0d_rresp@%02h", k, vq[k].addr), 32'(rsp), 32'(vq[k].exp_resp));
      end
    end

    // Basic frame: PERIOD=100, TARGET0=25, TARGET2 beyond period, TARGET1=0
    axi_write(7'h04, 32'd100, 4'hF, rsp);
    axi_write(7'h10, 32'd25,  4'hF, rsp);
    axi_write(7'h18, 32'd200, 4'hF, rsp);
    axi_write(7'h00, 32'h1,   4'hF, rsp);
    check("ctrl_en_bresp", 32'(rsp), 32'h0);
    wait_tick();
    measure_frame(0, hi, len);
    check("ch0_width_f1", 32'(hi), 32'd25);
    check("frame_len_f1", 32'(len), 32'd100);
    measure_frame(0, hi, len);
    check("ch0_width_f2", 32'(hi), 32'd25);
    check("frame_len_f2", 32'(len), 32'd100);
    measure_frame(1, hi, len);
    check("ch1_zero_width", 32'(hi), 32'd0);
    measure_frame(2, hi, len);
    check("ch2_const_high", 32'(hi), 32'd100);

    // Slew: bring CUR0 to 0, then step 10 toward 35
    wait_tick();
    axi_write(7'h10, 32'd0, 4'hF, rsp);
    wait_tick();
    axi_write(7'h08, 32'd10, 4'hF, rsp);
    axi_write(7'h00, 32'h3,  4'hF, rsp);
    wait_tick();
    axi_write(7'h10, 32'd35, 4'hF, rsp);
    axi_read(7'h0C, rd, rsp);
    check("status_before_slew", rd, 32'h0000_000E);
    wait_tick();
    measure_frame(0, hi, len);
    check("slew_w1", 32'(hi), 32'd10);
    measure_frame(0, hi, len);
    check("slew_w2", 32'(hi), 32'd20);
    measure_frame(0, hi, len);
    check("slew_w3", 32'(hi), 32'd30);
    measure_frame(0, hi, len);
    check("slew_w4", 32'(hi), 32'd35);
    axi_read(7'h0C, rd, rsp);
    check("status_after_slew", rd, 32'h0000_000F);

    // PERIOD 100 -> 50 mid-frame
    axi_write(7'h00, 32'h1, 4'hF, rsp);
    wait_tick();
    t0 = cyc;
    #1;
    tick_q.delete();
    tick_rec = 1'b1;
    repeat (20) @(negedge clk);
    axi_write(7'h04, 32'd50, 4'hF, rsp);
    wait_ticks(3);
    if (tick_q.size() >= 3) begin
      check("period_cur_frame", tick_q[0] - t0, 32'd100);
      check("period_new_1", tick_q[1] - tick_q[0], 32'd50);
      check("period_new_2", tick_q[2] - tick_q[1], 32'd50);
    end

    // PERIOD below 2 is treated as 2; CUR0=35 gives constant high
    axi_write(7'h04, 32'd1, 4'hF, rsp);
    #1;
    tick_q.delete();
    wait_ticks(3);
    if (tick_q.size() >= 3) begin
      check("period_min_1", tick_q[1] - tick_q[0], 32'd2);
      check("period_min_2", tick_q[2] - tick_q[1], 32'd2);
    end
    check("pwm_short_frame", 32'(pwm_out[1:0]), 32'b01);
    tick_rec = 1'b0;

    // EN=0 forces outputs low; EN 0->1 starts a fresh frame with reloaded period
    axi_write(7'h00, 32'h0, 4'hF, rsp);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (pwm_out != '0 || frame_tick) seen++;
      @(negedge clk);
    end
    check("disabled_outputs_low", 32'(seen), 32'd0);
    axi_write(7'h04, 32'd100, 4'hF, rsp);
    #1;
    tick_q.delete();
    tick_rec = 1'b1;
    axi_write(7'h00, 32'h1, 4'hF, rsp);
    c0 = cyc;
    wait_ticks(2);
    if (tick_q.size() >= 2) begin
      check("enable_fresh_frame", 32'((tick_q[0] - c0) <= 1), 32'd1);
      check("enable_period_reload", tick_q[1] - tick_q[0], 32'd100);
    end
    tick_rec = 1'b0;

    // AWVALID three cycles ahead of WVALID, BREADY held low five cycles
    @(negedge clk);
    awaddr = 7'h08; wdata = 32'h0000_0007; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0;
    early = 1'b0;
    repeat (3) begin @(negedge clk); if (awready || wready) early = 1'b1; end
    check("no_ready_before_wvalid", 32'(early), 32'd0);
    wvalid = 1'b1;
    seen = 0;
    while (!awready && seen < 20) begin @(negedge clk); seen++; end
    if (seen >= 20) timeout("split_awready");
    check("aw_w_ready_together", 32'({awready, wready}), 32'b11);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    bcnt = 0; early = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (bvalid) bcnt++;
      if (awready) early = 1'b1;
      @(negedge clk);
    end
    check("bvalid_held", 32'(bcnt), 32'd5);
    check("no_second_accept", 32'(early), 32'd0);
    check("bvalid_still_high", 32'(bvalid), 32'd1);
    bready = 1'b1;
    @(negedge clk);
    check("bvalid_dropped", 32'(bvalid), 32'd0);
    axi_read(7'h08, rd, rsp);
    check("split_write_value", rd, 32'h0000_0007);

    // Simultaneous read and write of TARGET3 returns the old value
    @(negedge clk);
    awaddr = 7'h1C; wdata = 32'h99; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    araddr = 7'h1C; arvalid = 1'b1; rready = 1'b1;
    @(negedge clk);
    check("simul_readies", 32'({awready, wready, arready}), 32'b111);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("simul_valids", 32'({bvalid, rvalid}), 32'b11);
    check("simul_old_data", rdata, 32'h0);
    @(negedge clk);
    axi_read(7'h1C, rd, rsp);
    check("simul_new_data", rd, 32'h0000_0099);

    // Reset while RVALID is held
    check("ch2_high_before_reset", 32'(pwm_out[2]), 32'd1);
    @(negedge clk);
    araddr = 7'h04; arvalid = 1'b1; rready = 1'b0;
    seen = 0;
    while (!arready && seen < 20) begin @(negedge clk); seen++; end
    if (seen >= 20) timeout("rst_arready");
    @(negedge clk);
    arvalid = 1'b0;
    repeat (2) @(negedge clk);
    check("rvalid_held", 32'(rvalid), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_rvalid_dropped", 32'({rvalid, arready, bvalid}), 32'h0);
    check("rst_pwm_low", 32'({frame_tick, pwm_out}), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    rready = 1'b1;
    axi_read(7'h00, rd, rsp);
    check("rst_ctrl", rd, 32'h0);
    axi_read(7'h04, rd, rsp);
    check("rst_period", rd, 32'd2000000);
    axi_read(7'h08, rd, rsp);
    check("rst_step", rd, 32'h0);
    axi_read(7'h18, rd, rsp);
    check("rst_target2", rd, 32'h0);
    axi_read(7'h0C, rd, rsp);
    check("rst_status", rd, 32'h0000_000F);
    repeat (5) @(negedge clk);
    check("rst_stays_idle", 32'({frame_tick, pwm_out}), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
